// File: rtl/sky_prog_seq_if.sv
// Stream-in and instruction-memory write port bundle for the program-load sequencer.
// The slave modport is the sequencer side; the master modport is the host/memory side.
interface sky_prog_seq_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sky_prog_seq.sv
// Program-load and run sequencer: loads a length-prefixed byte stream into the core's
// instruction memory, pulses the core reset, then supervises the run until HLT or watchdog.
//
// state | meaning
// IDLE  | waiting for start
// LEN   | accepting the length byte
// LOAD  | accepting program bytes, one memory write per byte
// CRST  | one-cycle core reset pulse
// RUN   | core executing, watchdog counting down
// DONE  | core halted, run_cycles held
// ERR   | bad length / timeout / abort, err held
module sky_prog_seq #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 25,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  sky_prog_seq_if.slave bus,
  output logic        core_rst,
  output logic        core_run,
  input  logic        core_halted,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [15:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CRST,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]  DEPTH_B   = 8'(DEPTH);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  state_t            state, state_nx;
  logic [7:0]        len_q, len_nx;
  logic [7:0]        count_q, count_nx;
  logic [7:0]        count_inc;
  logic [1:0]        err_q, err_nx;
  logic [15:0]       rc_q, rc_nx;
  logic [15:0]       wdog_q, wdog_nx;
  logic              we_q, we_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [7:0]        wdata_q, wdata_nx;
  logic              in_rdy;
  logic              xfer;
  logic              len_ok;
  logic              wd_tc;
  logic              is_busy;

  assign in_rdy    = (state == S_LEN) || (state == S_LOAD);
  assign xfer      = bus.in_valid && in_rdy;
  assign len_ok    = (bus.in_data >= 8'd1) && (bus.in_data <= DEPTH_B);
  assign count_inc = count_q + 8'd1;
  assign wd_tc     = (wdog_q == 16'd1);
  assign is_busy   = (state == S_LEN) || (state == S_LOAD) ||
                     (state == S_CRST) || (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= ERR_NONE;
      rc_q    <= '0;
      wdog_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      len_q   <= len_nx;
      count_q <= count_nx;
      err_q   <= err_nx;
      rc_q    <= rc_nx;
      wdog_q  <= wdog_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    len_nx   = len_q;
    count_nx = count_q;
    err_nx   = err_q;
    rc_nx    = rc_q;
    wdog_nx  = wdog_q;
    we_nx    = 1'b0;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nx = S_LEN;
          err_nx   = ERR_NONE;
          rc_nx    = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (len_ok) begin
            len_nx   = bus.in_data;
            count_nx = '0;
            state_nx = S_LOAD;
          end else begin
            err_nx   = ERR_LEN;
            state_nx = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_nx    = 1'b1;
          addr_nx  = count_q[ADDR_W-1:0];
          wdata_nx = bus.in_data;
          count_nx = count_inc;
          if (count_inc == len_q) state_nx = S_CRST;
        end
      end
      S_CRST: begin
        wdog_nx  = TIMEOUT_W;
        state_nx = S_RUN;
      end
      S_RUN: begin
        rc_nx   = (rc_q == 16'hFFFF) ? rc_q : rc_q + 16'd1;
        wdog_nx = wdog_q - 16'd1;
        // halt beats the watchdog when both land in the same cycle
        if (core_halted) begin
          state_nx = S_DONE;
        end else if (wd_tc) begin
          err_nx   = ERR_TIMEOUT;
          state_nx = S_ERR;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (abort) begin
      we_nx = 1'b0;
      if (is_busy) begin
        state_nx = S_ERR;
        err_nx   = ERR_ABORT;
      end else begin
        state_nx = S_IDLE;
        err_nx   = ERR_NONE;
        rc_nx    = rc_q;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst      = (state == S_CRST);
  assign core_run      = (state == S_RUN);
  assign busy          = is_busy;
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERR) ? err_q : ERR_NONE;
  assign run_cycles    = rc_q;

endmodule

// File: tb/tb_sky_prog_seq.sv
// Scoreboard bench for sky_prog_seq: stimulus pushes expected memory writes and session
// outcomes, a negedge monitor pops and compares them as the sequencer produces them.
module tb_sky_prog_seq;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 25;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, core_halted;
  logic        core_rst, core_run, busy, done;
  logic [1:0]  err;
  logic [15:0] run_cycles;

  sky_prog_seq_if #(.ADDR_W(ADDR_W)) bus ();

  sky_prog_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .core_rst(core_rst), .core_run(core_run), .core_halted(core_halted),
    .busy(busy), .done(done), .err(err), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [1:0] e; logic [15:0] rc; int runs; int rsts; } end_t;

  wr_t        exp_wr[$];
  end_t       exp_end[$];
  logic [7:0] prog[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         halt_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of one session from first principles: bad length, halt within budget, or watchdog
  function automatic end_t model(input int len_b, input int h);
    end_t r;
    if (len_b < 1 || len_b > DEPTH) r = '{2'd1, 16'd0, 0, 0};
    else if (h >= 1 && h <= TIMEOUT) r = '{2'd0, 16'(h), h, 1};
    else r = '{2'd2, 16'(TIMEOUT), TIMEOUT, 1};
    return r;
  endfunction

  // Core stand-in: raises core_halted during its halt_at-th execute cycle
  initial begin
    int cyc;
    cyc = 0;
    core_halted = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      core_halted = core_run && (halt_at != 0) && (cyc == halt_at - 1);
      @(negedge clk);
      if (core_rst) cyc = 0;
      if (core_run) cyc++;
    end
  end

  initial begin
    int  runs, rsts;
    bit  term, term_prev;
    wr_t w;
    end_t e;
    runs = 0; rsts = 0; term_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        runs = 0; rsts = 0; term_prev = 0;
      end else begin
        if (bus.mem_we) begin
          if (exp_wr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_addr, bus.mem_wdata);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(w.a));
            chk("wr_data", 32'(bus.mem_wdata), 32'(w.d));
          end
        end
        if (core_run) runs++;
        if (core_rst) rsts++;
        term = done || (err != 2'd0);
        if (term && !term_prev) begin
          if (exp_end.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_end: err %0d run_cycles %0d, none expected", err, run_cycles);
          end else begin
            e = exp_end.pop_front();
            chk("err", 32'(err), 32'(e.e));
            chk("done", 32'(done), (e.e == 2'd0) ? 32'd1 : 32'd0);
            chk("run_cycles", 32'(run_cycles), 32'(e.rc));
            chk("core_run_cycles", runs, e.runs);
            chk("core_rst_pulses", rsts, e.rsts);
          end
          runs = 0; rsts = 0;
        end
        term_prev = term;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
    bit ok;
    logic rdy;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      step();
      if (chk_rdy) chk("in_ready_load_gap", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      rdy = bus.in_ready;
      step();
      if (rdy) begin ok = 1; break; end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL byte_accept_timeout: byte %0h not accepted within 20 cycles", b);
    end
  endtask

  task automatic load_prog(input int len_b, input int n_send, input bit toggle);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("in_ready_len", 32'(bus.in_ready), 32'd1);
    send_byte(8'(len_b), toggle ? 1 : 0, toggle);
    if (len_b >= 1 && len_b <= DEPTH) begin
      for (int i = 0; i < n_send; i++) begin
        exp_wr.push_back('{5'(i), prog[i]});
        send_byte(prog[i], toggle ? 1 : 0, toggle);
      end
    end
  endtask

  task automatic wait_end();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (done || err != 2'd0) begin ok = 1; break; end
      step();
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL session_end_timeout: no DONE/ERR within 300 cycles");
    end
    step();
  endtask

  task automatic session(input int len_b, input int h, input bit toggle);
    halt_at = h;
    exp_end.push_back(model(len_b, h));
    load_prog(len_b, len_b, toggle);
    wait_end();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({tag, "_core_run"}, 32'(core_run), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    int len_b, h;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    chk_all_zero("reset");

    prog = '{8'h01, 8'h05, 8'h0A};
    session(3, 4, 0);
    session(3, 4, 1);

    session(0, 0, 0);
    session(26, 0, 0);

    prog = '{8'h11, 8'h22};
    session(2, 0, 0);
    prog = '{8'h3C, 8'h4D, 8'h5E};
    session(3, TIMEOUT, 0);

    // abort after 2 of 5 bytes
    prog = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    halt_at = 0;
    exp_end.push_back('{2'd3, 16'd0, 0, 0});
    load_prog(5, 2, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_err", 32'(err), 32'd3);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'hC3;
    repeat (3) step();
    bus.in_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_err", 32'(err), 32'd0);
    chk("abort_idle_done", 32'(done), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // reset during RUN discards the session
    prog = '{8'h77, 8'h88};
    halt_at = 0;
    load_prog(2, 2, 0);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (core_run) begin ok = 1; break; end
      step();
    end
    chk("reached_run", 32'(ok), 32'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst_in_run");

    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 7) == 0)
        len_b = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 255));
      else
        len_b = int'($urandom_range(1, DEPTH));
      h = int'($urandom_range(0, TIMEOUT + 2));
      prog.delete();
      for (int i = 0; i < len_b && i < 256; i++) prog.push_back(8'($urandom));
      session(len_b, h, 1'($urandom_range(0, 1)));
    end

    repeat (4) step();
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_end_drained", exp_end.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
